// File: rtl/control_pipe.sv
// Pipelined RV32I control decoder with valid/ready handshake, flush and a saturating counter.
// Optional illegal-instruction trapping is enabled by defining CONTROL_ILLEGAL_TRAP_EN.
package riscv_control_pkg;

  typedef enum logic [3:0] {
    alu_add  = 4'd0,
    alu_sub  = 4'd1,
    alu_sll  = 4'd2,
    alu_slt  = 4'd3,
    alu_sltu = 4'd4,
    alu_xor  = 4'd5,
    alu_srl  = 4'd6,
    alu_sra  = 4'd7,
    alu_or   = 4'd8,
    alu_and  = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    branch_neq;
    logic    jump;
    alu_op_t alu_op;
  } riscv_control_t;

endpackage

module control_pipe
  import riscv_control_pkg::*;
#(
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic                 flush_in,
  output riscv_control_t       control_out,
  output logic [4:0]           rd_out,
  output logic [4:0]           rs1_out,
  output logic [4:0]           rs2_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 illegal_out,
  output logic [CNT_W-1:0]     decode_cnt_out
);

  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJump  = 7'b1101111;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] F7Alt   = 7'b0100000;

  typedef struct packed {
    riscv_control_t ctrl;
    logic [4:0]     rd;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic           illegal;
  } stage_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  stage_t     dec;
  logic       illegal_d;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];

  // Shared funct3 map for OP and OP-IMM; only OP may select SUB.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic [6:0] f7,
                                       input logic is_reg);
    alu_op_t op;
    case (f3)
      3'b000:  op = (is_reg && f7 == F7Alt) ? alu_sub : alu_add;
      3'b001:  op = alu_sll;
      3'b010:  op = alu_slt;
      3'b011:  op = alu_sltu;
      3'b100:  op = alu_xor;
      3'b101:  op = (f7 == F7Alt) ? alu_sra : alu_srl;
      3'b110:  op = alu_or;
      default: op = alu_and;
    endcase
    return op;
  endfunction

`ifdef CONTROL_ILLEGAL_TRAP_EN
  logic known_op;
  assign known_op = opcode inside {OpBr, OpJump, OpLoad, OpStore, OpImm, OpReg};
`endif

  always_comb begin
    dec             = '0;
    dec.ctrl.alu_op = alu_add;
    dec.rd          = instr_in[11:7];
    dec.rs1         = instr_in[19:15];
    dec.rs2         = instr_in[24:20];
    case (opcode)
      OpBr: begin
        dec.ctrl.alu_op = alu_sub;
        if (funct3 == 3'b001) dec.ctrl.branch_neq = 1'b1;
        else                  dec.ctrl.branch     = 1'b1;
      end
      OpJump: begin
        dec.ctrl.jump    = 1'b1;
        dec.ctrl.alu_src = 1'b1;
      end
      OpLoad: begin
        dec.ctrl.mem_read   = 1'b1;
        dec.ctrl.mem_to_reg = 1'b1;
        dec.ctrl.reg_write  = 1'b1;
        dec.ctrl.alu_src    = 1'b1;
      end
      OpStore: begin
        dec.ctrl.mem_write = 1'b1;
        dec.ctrl.alu_src   = 1'b1;
      end
      OpImm: begin
        dec.ctrl.reg_write = 1'b1;
        dec.ctrl.alu_src   = 1'b1;
        dec.ctrl.alu_op    = arith_op(funct3, funct7, 1'b0);
      end
      OpReg: begin
        dec.ctrl.reg_write = 1'b1;
        dec.ctrl.alu_op    = arith_op(funct3, funct7, 1'b1);
      end
      default: ;
    endcase

`ifdef CONTROL_ILLEGAL_TRAP_EN
    illegal_d = ~known_op
              | ((opcode == OpReg) & (funct7 != 7'b0000000) & (funct7 != F7Alt))
              | ((opcode == OpReg) & (funct7 == F7Alt) & (funct3 != 3'b000)
                 & (funct3 != 3'b101))
              | ((opcode == OpImm) & (funct3 == 3'b001) & (funct7 != 7'b0000000));
    if (illegal_d) begin
      dec.ctrl.reg_write  = 1'b0;
      dec.ctrl.mem_read   = 1'b0;
      dec.ctrl.mem_write  = 1'b0;
      dec.ctrl.mem_to_reg = 1'b0;
      dec.ctrl.branch     = 1'b0;
      dec.ctrl.branch_neq = 1'b0;
      dec.ctrl.jump       = 1'b0;
    end
`else
    illegal_d = 1'b0;
`endif
    dec.illegal = illegal_d;
  end

  logic [STAGES-1:0] valid_q;
  stage_t            stage_q   [STAGES];
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] src_valid;
  stage_t            src       [STAGES];
  logic              accept;
  logic              xfer;
  logic [CNT_W-1:0]  cnt_q;

  // A stage advances if it or any stage downstream of it is empty, or the sink is ready.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      adv[k] = ready_in;
      for (int j = k; j < int'(STAGES); j++) begin
        if (!valid_q[j]) adv[k] = 1'b1;
      end
    end
  end

  assign ready_out = adv[0] & ~flush_in & rst_n;
  assign accept    = valid_in & ready_out;
  assign xfer      = valid_q[STAGES-1] & ready_in;

  always_comb begin
    src_valid[0] = accept;
    src[0]       = dec;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_valid[k] = valid_q[k-1];
      src[k]       = stage_q[k-1];
    end
  end

  // All-zero stage data decodes as alu_add with every flag clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < int'(STAGES); k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (flush_in) begin
          valid_q[k] <= 1'b0;
        end else if (adv[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) stage_q[k] <= src[k];
        end
      end
      if (xfer && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign valid_out      = valid_q[STAGES-1];
  assign control_out    = stage_q[STAGES-1].ctrl;
  assign rd_out         = stage_q[STAGES-1].rd;
  assign rs1_out        = stage_q[STAGES-1].rs1;
  assign rs2_out        = stage_q[STAGES-1].rs2;
  assign illegal_out    = stage_q[STAGES-1].illegal;
  assign decode_cnt_out = cnt_q;

endmodule
